// File: rtl/hello_world.sv
// hello_world: two-input registered logic cell behind the input pads.
// Each asynchronous pad input is synchronised into the clk domain and then
// glitch-filtered. The two filtered values are combined by a Boolean
// function chosen at compile time, and the result is registered onto the
// output pad.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth per input (2..4)
//   FILTER_LEN   cycles a new synchronised value must hold before it is
//                accepted (1..15)
//   FUNC         0 = AND, 1 = OR, 2 = XOR, 3 = NAND
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   a, b     asynchronous pad inputs
//   out      registered FUNC(a_f, b_f)
//   out_chg  one-cycle pulse in the cycle out takes a new value

// hello_world_in: one synchroniser chain followed by a hold-time filter.
//   clk, rst_n  as above
//   d           asynchronous pad input
//   q           filtered, synchronised value (x_f)
module hello_world_in #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   x_s;
   logic                   x_f;
   logic [3:0]             x_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
      end
   end

   assign x_s = sync[SYNC_STAGES-1];

   // The counter restarts whenever the synchronised value returns to the
   // accepted value, so only an unbroken run of FILTER_LEN cycles is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_f   <= 1'b0;
         x_cnt <= '0;
      end else if (x_s == x_f) begin
         x_cnt <= '0;
      end else if (x_cnt == CNT_MAX) begin
         x_f   <= x_s;
         x_cnt <= '0;
      end else begin
         x_cnt <= x_cnt + 4'd1;
      end
   end

   assign q = x_f;

endmodule

module hello_world #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4,
   parameter logic [1:0]  FUNC        = 2'd0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   output logic out,
   output logic out_chg
);

   // FUNC(0,0): only NAND yields 1 for two zero inputs.
   localparam logic OUT_RST = (FUNC == 2'd3);

   logic a_f;
   logic b_f;
   logic f_val;

   hello_world_in #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_in_a (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (a),
      .q     (a_f)
   );

   hello_world_in #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_in_b (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (b),
      .q     (b_f)
   );

   always_comb begin
      f_val = 1'b0;
      case (FUNC)
         2'd0:    f_val = a_f & b_f;
         2'd1:    f_val = a_f | b_f;
         2'd2:    f_val = a_f ^ b_f;
         default: f_val = ~(a_f & b_f);
      endcase
   end

   // out resets to FUNC(0,0), matching the reset state of the filters, so
   // the first edge after release never sees a difference and no spurious
   // out_chg pulse appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out     <= OUT_RST;
         out_chg <= 1'b0;
      end else begin
         out     <= f_val;
         out_chg <= (f_val != out);
      end
   end

endmodule

// File: tb/tb_hello_world.sv
module tb_hello_world;

   typedef struct {
      logic        v;
      int unsigned cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic a0, b0, a1, b1, a2, b2;
   logic out0, chg0, out1, chg1, out2, chg2;

   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hello_world #(.SYNC_STAGES(2), .FILTER_LEN(4), .FUNC(2'd0)) u_and (
      .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .out(out0), .out_chg(chg0));
   hello_world #(.SYNC_STAGES(2), .FILTER_LEN(4), .FUNC(2'd3)) u_nand (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .out(out1), .out_chg(chg1));
   hello_world #(.SYNC_STAGES(2), .FILTER_LEN(1), .FUNC(2'd2)) u_xor (
      .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .out(out2), .out_chg(chg2));

   task automatic check_bit(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b time=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_int(input string nm, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string nm, input logic o);
      checks++;
      errors++;
      $display("FAIL %s actual=out_chg@cyc%0d(out=%b) required=no_change", nm, cyc, o);
   endtask

   // Monitors: every out_chg pulse must match the next expected transition
   // in value and in the edge it appears on.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && chg0 === 1'b1) begin
         if (q0.size() == 0) unexpected("and_chg", out0);
         else begin
            e = q0.pop_front();
            check_bit("and_out", out0, e.v);
            check_int("and_edge", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && chg1 === 1'b1) begin
         if (q1.size() == 0) unexpected("nand_chg", out1);
         else begin
            e = q1.pop_front();
            check_bit("nand_out", out1, e.v);
            check_int("nand_edge", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && chg2 === 1'b1) begin
         if (q2.size() == 0) unexpected("xor_chg", out2);
         else begin
            e = q2.pop_front();
            check_bit("xor_out", out2, e.v);
            check_int("xor_edge", cyc, e.cyc);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expected edge for a change driven now: captured at edge cyc+1, seen at
   // the output lat edges later.
   task automatic push0(input logic v, input int unsigned lat);
      exp_t e;
      e.v = v; e.cyc = cyc + 1 + lat;
      q0.push_back(e);
   endtask

   task automatic push1(input logic v, input int unsigned lat);
      exp_t e;
      e.v = v; e.cyc = cyc + 1 + lat;
      q1.push_back(e);
   endtask

   task automatic push2(input logic v, input int unsigned lat);
      exp_t e;
      e.v = v; e.cyc = cyc + 1 + lat;
      q2.push_back(e);
   endtask

   initial begin
      rst_n = 1'b1;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0;
      #3 rst_n = 1'b0;

      // reset state
      wait_cyc(2);
      check_bit("rst_and_out", out0, 1'b0);
      check_bit("rst_and_chg", chg0, 1'b0);
      check_bit("rst_nand_out", out1, 1'b1);
      check_bit("rst_nand_chg", chg1, 1'b0);
      check_bit("rst_xor_out", out2, 1'b0);
      rst_n = 1'b1;
      wait_cyc(20);
      check_bit("idle_and_out", out0, 1'b0);
      check_bit("idle_nand_out", out1, 1'b1);

      // AND truth table
      b0 = 1;
      wait_cyc(10);
      check_bit("and_01", out0, 1'b0);
      a0 = 1; b0 = 0;
      wait_cyc(10);
      check_bit("and_10", out0, 1'b0);
      b0 = 1; push0(1'b1, 6);
      wait_cyc(10);
      check_bit("and_11", out0, 1'b1);

      // glitch rejection: 3-cycle low is dropped, 4-cycle low passes
      a0 = 0;
      wait_cyc(3);
      a0 = 1;
      wait_cyc(12);
      check_bit("glitch3_out", out0, 1'b1);
      a0 = 0; push0(1'b0, 6);
      wait_cyc(4);
      a0 = 1; push0(1'b1, 6);
      wait_cyc(14);
      check_bit("glitch4_out", out0, 1'b1);

      // reset in the middle of a pending filter count
      a0 = 0; b0 = 0; push0(1'b0, 6);
      wait_cyc(12);
      a0 = 1; b0 = 1;
      wait_cyc(4);
      rst_n = 1'b0;
      #1;
      check_bit("midrst_out", out0, 1'b0);
      check_bit("midrst_chg", chg0, 1'b0);
      wait_cyc(3);
      rst_n = 1'b1; push0(1'b1, 6);
      wait_cyc(10);
      check_bit("midrst_after", out0, 1'b1);
      a0 = 0; b0 = 0; push0(1'b0, 6);
      wait_cyc(10);

      // NAND
      check_bit("nand_idle", out1, 1'b1);
      a1 = 1; b1 = 1; push1(1'b0, 6);
      wait_cyc(10);
      check_bit("nand_11", out1, 1'b0);
      a1 = 0; b1 = 0; push1(1'b1, 6);
      wait_cyc(10);
      check_bit("nand_00", out1, 1'b1);

      // XOR, FILTER_LEN=1: out follows a three edges later
      for (int i = 0; i < 8; i++) begin
         a2 = ~a2; push2(a2, 3);
         wait_cyc(2);
      end
      wait_cyc(6);
      check_bit("xor_final", out2, 1'b0);

      check_int("and_pending", q0.size(), 0);
      check_int("nand_pending", q1.size(), 0);
      check_int("xor_pending", q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
